// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache traffic onto a single RAM port. Dcache has
// priority; a saturating counter forces an icache grant after STARVE_LIMIT dcache grants.
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] RAM_FREE     = 2'b00,
  parameter logic [1:0] RAM_BUSY     = 2'b01,
  parameter logic [1:0] RAM_ACCESS   = 2'b10,
  parameter logic [1:0] RAM_ERROR    = 2'b11
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       dreq;
  logic       access;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iREN && starve_cnt == LIMIT) begin
            state      <= ISERVE;
            starve_cnt <= '0;
          end else if (dreq) begin
            state <= DSERVE;
            if (iREN && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 3'd1;
          end else if (iREN) begin
            state      <= ISERVE;
            starve_cnt <= '0;
          end
        end
        DSERVE, ISERVE: begin
          // A withdrawn request abandons the grant before RAM status is considered.
          if ((state == DSERVE) ? !dreq : !iREN) begin
            state <= IDLE;
          end else begin
            case (ramstate)
              RAM_ACCESS:         state <= IDLE;
              RAM_ERROR:          err   <= 1'b1;
              RAM_FREE, RAM_BUSY: state <= state;
              default:            state <= state;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~(dreq & access);
      end
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~(iREN & access);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: completions are checked by a scoreboard
// monitor against expectations queued by the stimulus.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'b00;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

  typedef struct packed {logic is_i; logic [31:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic is_i, input logic [31:0] data);
    exp_t x;
    x.is_i = is_i;
    x.data = data;
    q.push_back(x);
  endtask

  // Scoreboard monitor: any wait=0 must match the next queued completion.
  always @(negedge CLK) begin
    if (nRST && (!iwait || !dwait)) begin
      checks++;
      if (!iwait && !dwait) begin
        errors++;
        $display("FAIL dual_completion got iwait=0 dwait=0 expected one owner");
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_completion got %s expected none", !iwait ? "icache" : "dcache");
      end else begin
        e = q.pop_front();
        if (e.is_i != !iwait || e.data != (!iwait ? iload : dload)) begin
          errors++;
          $display("FAIL completion got is_i=%0b data=%h expected is_i=%0b data=%h",
                   !iwait, (!iwait ? iload : dload), e.is_i, e.data);
        end
      end
    end
  end

  initial begin
    // Reset with both requesters asserted
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h0000_1234; ramstate = BUSY;
    tick();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    tick();
    chk("rst_err", 32'(err), 32'd0);
    nRST = 1'b1;
    #1;
    chk("post_rst_idle_ramREN", 32'(ramREN), 32'd0);
    chk("post_rst_idle_ramaddr", ramaddr, 32'd0);
    tick();
    chk("dserve_ramaddr", ramaddr, 32'h0000_1234);
    chk("dserve_ramREN", 32'(ramREN), 32'd1);

    // Withdraw dREN while RAM is busy
    iREN = 1'b0; dREN = 1'b0;
    #1;
    chk("withdraw_ramREN", 32'(ramREN), 32'd0);
    chk("withdraw_ramWEN", 32'(ramWEN), 32'd0);
    chk("withdraw_dwait", 32'(dwait), 32'd1);
    tick();
    chk("withdraw_idle_ramaddr", ramaddr, 32'd0);

    // Dcache read: BUSY x2 then ACCESS
    dREN = 1'b1; daddr = 32'h0000_0040;
    tick();
    chk("dread_ramaddr", ramaddr, 32'h0000_0040);
    chk("dread_busy_dwait", 32'(dwait), 32'd1);
    tick();
    chk("dread_busy2_dwait", 32'(dwait), 32'd1);
    tick();
    ramstate = ACC; ramload = 32'hDEAD_BEEF;
    push(1'b0, 32'hDEAD_BEEF);
    #1;
    chk("dread_acc_dwait", 32'(dwait), 32'd0);
    chk("dread_acc_dload", dload, 32'hDEAD_BEEF);
    tick();
    ramstate = FREE;
    #1;
    chk("dread_after_ramREN", 32'(ramREN), 32'd0);
    chk("dread_after_ramaddr", ramaddr, 32'd0);
    chk("dread_after_dwait", 32'(dwait), 32'd1);
    dREN = 1'b0;
    tick();

    // Write wins over simultaneous read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_3100; dstore = 32'h0000_0007;
    tick();
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramstore", ramstore, 32'h0000_0007);
    chk("wr_ramaddr", ramaddr, 32'h0000_3100);
    ramstate = ACC; ramload = 32'h0000_0055;
    push(1'b0, 32'h0000_0055);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();

    // RAM error during icache service
    iREN = 1'b1; iaddr = 32'h0000_0080; ramstate = ERR;
    tick();
    chk("ierr_err_before", 32'(err), 32'd0);
    chk("ierr_ramREN", 32'(ramREN), 32'd1);
    chk("ierr_ramaddr", ramaddr, 32'h0000_0080);
    tick();
    chk("ierr_err_set", 32'(err), 32'd1);
    chk("ierr_iwait", 32'(iwait), 32'd1);
    tick();
    tick();
    chk("ierr_iwait3", 32'(iwait), 32'd1);
    ramstate = ACC; ramload = 32'hCAFE_0001;
    push(1'b1, 32'hCAFE_0001);
    #1;
    chk("ierr_acc_iwait", 32'(iwait), 32'd0);
    chk("ierr_acc_iload", iload, 32'hCAFE_0001);
    tick();
    ramstate = FREE;
    #1;
    chk("ierr_err_sticky", 32'(err), 32'd1);
    chk("ierr_idle_ramREN", 32'(ramREN), 32'd0);
    iREN = 1'b0;
    tick();

    // Starvation guard: fresh reset, both requesters held, every access 1-cycle
    nRST = 1'b0;
    tick();
    tick();
    chk("rst2_err_clear", 32'(err), 32'd0);
    nRST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h0000_0100; iaddr = 32'h0000_0200;
    ramstate = ACC; ramload = 32'h1111_2222;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1'b0, 32'h1111_2222);
      push(1'b1, 32'h1111_2222);
    end
    for (int c = 0; c < 20; c++) tick();
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick();
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches.
- Arbitrates their miss, write-back and flush traffic onto the single RAM port.
- Registered grant FSM; dcache has priority, with a starvation guard for icache fetches.
- Returns per-requester wait/load handshakes that the caches' READ/WB/FLUSH states consume.

Parameters:
STARVE_LIMIT, 4, consecutive dcache grants allowed while iREN is pending before the icache is forced a grant
RAM_FREE, 2'b00, ramstate encoding: idle
RAM_BUSY, 2'b01, ramstate encoding: access in progress
RAM_ACCESS, 2'b10, ramstate encoding: access completes this cycle
RAM_ERROR, 2'b11, ramstate encoding: fault

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  synchronous active-low reset, sampled on rising CLK
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  0 = icache access completes this cycle
iload  out  32  instruction word to icache
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  0 = dcache access completes this cycle
dload  out  32  data word to dcache
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  RAM status
err  out  1  sticky RAM error flag

Behaviour:
- Reset (nRST=0 at a rising edge): state=IDLE, starve_cnt=0, err=0.
  - Combinational outputs while in IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
  - Reset mid-transaction abandons it; no completion pulse is issued.
- States: IDLE, DSERVE, ISERVE.
- IDLE:
  - dreq = dREN|dWEN.
  - If iREN && starve_cnt==STARVE_LIMIT -> ISERVE, starve_cnt<=0.
  - Else if dreq -> DSERVE; starve_cnt increments (saturating at STARVE_LIMIT) when iREN is also high.
  - Else if iREN -> ISERVE, starve_cnt<=0.
  - Else stay in IDLE.
  - No RAM strobes and both waits 1 in IDLE: the grant costs one cycle.
- DSERVE:
  - ramaddr=daddr and ramstore=dstore, driven combinationally from live inputs.
  - ramWEN=dWEN; ramREN=dREN&~dWEN, so a write wins if both are asserted.
  - dload=ramload.
  - If ramstate==RAM_ACCESS: dwait=0 this cycle, next state IDLE.
  - If dREN==0 and dWEN==0 (request withdrawn): strobes 0, dwait=1, next state IDLE.
  - iwait stays 1.
- ISERVE:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, iload=ramload.
  - If ramstate==RAM_ACCESS: iwait=0, next state IDLE.
  - If iREN drops: next state IDLE.
  - dwait stays 1.
- Completion occurs only in the cycle ramstate==RAM_ACCESS, and only the current owner sees wait=0.
  - Multi-word cache bursts (two words per block) re-arbitrate between words, so each word costs grant cycle + RAM latency.
- RAM_ERROR while serving: err<=1 (sticky until reset), owner's wait stays 1, state stays put; RAM retries.
- RAM_FREE/RAM_BUSY while serving: hold state, wait=1.
- Requests arriving mid-service are not lost; they are evaluated in the next IDLE cycle.
- starve_cnt is 3 bits wide, saturating, never wraps.

Test Plan:
- Reset with iREN=1 and dREN=1 held -> during reset iwait=dwait=1, ramREN=ramWEN=0; first post-reset cycle IDLE, next cycle DSERVE with ramaddr=daddr.
- dREN=1, daddr=0x0000_0040, ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> dwait=0 and dload=0xDEADBEEF in exactly that cycle; IDLE the next cycle.
- dWEN=1 and dREN=1 together, daddr=0x3100, dstore=0x0000_0007 -> ramWEN=1, ramREN=0, ramstore=0x7.
- iREN and dREN both held continuously, every access 1-cycle ACCESS -> exactly 4 dcache completions, then 1 icache completion with iload=ramload, repeating.
- dREN dropped while ramstate=BUSY in DSERVE -> strobes 0 that cycle, IDLE next cycle, no dwait=0 pulse.
- ramstate=ERROR for 3 cycles during ISERVE, then ACCESS -> err=1 and remains 1, iwait=0 only on the ACCESS cycle.
